// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, data-memory base and MEM-stage sequencer state encodings
package mem_stage_pkg;
  localparam int LEN_REG_ADDRESS = 4;
  localparam int LEN_SRAM_ADDR = 18;
  localparam int LEN_SRAM_DATA = 16;
  localparam int DATA_MEM_BASE_DEF = 1024;
  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_LO   = 2'd1,
    MEM_ST_HI   = 2'd2,
    MEM_ST_DONE = 2'd3
  } mem_st_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: 16-bit SRAM pin bundle (address, write strobe, split data bus); master = controller, slave = memory
interface mem_stage_if;
  import mem_stage_pkg::*;
  logic [LEN_SRAM_ADDR-1:0] SRAM_ADDR;
  logic                     SRAM_WE_N;
  logic [LEN_SRAM_DATA-1:0] sram_dq_out;
  logic                     sram_dq_oe;
  logic [LEN_SRAM_DATA-1:0] sram_dq_in;
  modport master (output SRAM_ADDR, SRAM_WE_N, sram_dq_out, sram_dq_oe, input sram_dq_in);
  modport slave (input SRAM_ADDR, SRAM_WE_N, sram_dq_out, sram_dq_oe, output sram_dq_in);
endinterface

// File: rtl/mem_stage_sram_controller.sv
// sram_controller: splits a 32-bit access into two 16-bit SRAM halves; ports: start_rd/start_wr (capture-time flags), wr (held flag), addr/wdata (held), mem_rdata, freeze, sram bus
module sram_controller
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int DATA_MEM_BASE = DATA_MEM_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_rd,
  input  logic        start_wr,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_rdata,
  output logic        freeze,
  mem_stage_if.master sram
);
  localparam int CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  mem_st_t state, ns;
  logic [CW-1:0] cnt, ncnt;
  logic busy, nbusy, last, nwr;
  logic [15:0] w;
  always_comb begin
    busy = state == MEM_ST_LO || state == MEM_ST_HI;
    last = cnt == LAST;
    ns = busy ? (last ? (state == MEM_ST_LO ? MEM_ST_HI : MEM_ST_DONE) : state)
              : (start_rd || start_wr ? MEM_ST_LO : MEM_ST_IDLE);
    ncnt = busy && !last ? cnt + CW'(1) : '0;
    nbusy = ns == MEM_ST_LO || ns == MEM_ST_HI;
    nwr = busy ? wr : start_wr;
    w = 16'((addr - 32'(DATA_MEM_BASE)) >> 2);
  end
  assign freeze = busy;
  assign sram.SRAM_ADDR = state == MEM_ST_LO ? {w, 1'b0} : state == MEM_ST_HI ? {w, 1'b1} : '0;
  assign sram.sram_dq_out = state == MEM_ST_HI ? wdata[31:16] : wdata[15:0];
  // strobe and drive enable are registered from next-state so the pins never glitch;
  // the strobe releases on the last cycle of each half to give data hold time
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MEM_ST_IDLE;
      cnt <= '0;
      sram.SRAM_WE_N <= 1'b1;
      sram.sram_dq_oe <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state <= ns;
      cnt <= ncnt;
      sram.SRAM_WE_N <= !(nbusy && nwr && ncnt != LAST);
      sram.sram_dq_oe <= nbusy && nwr;
      if (busy && last && !wr) begin
        if (state == MEM_ST_LO) mem_rdata[15:0] <= sram.sram_dq_in;
        else mem_rdata[31:16] <= sram.sram_dq_in;
      end
    end
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EXE->MEM pipeline register plus SRAM sequencer; ports: exe_* in, MEM_*/mem_read_out/mem_rdata out, freeze/wb_valid stall control, sram bus
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int DATA_MEM_BASE = DATA_MEM_BASE_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exe_wb_enable,
  input  logic                       exe_mem_read,
  input  logic                       exe_mem_write,
  input  logic [LEN_REG_ADDRESS-1:0] exe_reg_dest,
  input  logic [31:0]                exe_alu_result,
  input  logic [31:0]                exe_val_rm,
  output logic                       MEM_wb_enable,
  output logic [LEN_REG_ADDRESS-1:0] MEM_reg_dest,
  output logic [31:0]                MEM_alu_result,
  output logic                       mem_read_out,
  output logic [31:0]                mem_rdata,
  output logic                       freeze,
  output logic                       wb_valid,
  mem_stage_if.master                sram
);
  logic mem_write;
  logic [31:0] val_rm;
  assign wb_valid = !freeze;
  // a store wins when both flags are set, so the load flag is masked for MEM/WB
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_wb_enable <= 1'b0;
      MEM_reg_dest <= '0;
      MEM_alu_result <= '0;
      mem_read_out <= 1'b0;
      mem_write <= 1'b0;
      val_rm <= '0;
    end else if (!freeze) begin
      MEM_wb_enable <= exe_wb_enable;
      MEM_reg_dest <= exe_reg_dest;
      MEM_alu_result <= exe_alu_result;
      mem_read_out <= exe_mem_read && !exe_mem_write;
      mem_write <= exe_mem_write;
      val_rm <= exe_val_rm;
    end
  end
  sram_controller #(.WAIT_CYCLES(WAIT_CYCLES), .DATA_MEM_BASE(DATA_MEM_BASE)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .start_rd(exe_mem_read),
    .start_wr(exe_mem_write),
    .wr(mem_write),
    .addr(MEM_alu_result),
    .wdata(val_rm),
    .mem_rdata(mem_rdata),
    .freeze(freeze),
    .sram(sram)
  );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage with behavioural 16-bit SRAM models
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic wb1 = 0, rd1 = 0, wr1 = 0;
  logic [LEN_REG_ADDRESS-1:0] dst1 = '0;
  logic [31:0] res1 = '0, val1 = '0;
  logic mwb1, mrd1, f1, v1;
  logic [LEN_REG_ADDRESS-1:0] mdst1;
  logic [31:0] malu1, rdata1;
  logic wr2 = 0;
  logic [31:0] res2 = '0, val2 = '0;
  logic mwb2, mrd2, f2, v2;
  logic [LEN_REG_ADDRESS-1:0] mdst2;
  logic [31:0] malu2, rdata2;
  mem_stage_if s1 ();
  mem_stage_if s2 ();
  logic [15:0] mem1 [16] = '{4: 16'h1234, 5: 16'h5678, default: 16'h0};
  logic [15:0] mem2 [16] = '{default: 16'h0};
  assign s1.sram_dq_in = mem1[s1.SRAM_ADDR[3:0]];
  assign s2.sram_dq_in = mem2[s2.SRAM_ADDR[3:0]];
  always @(posedge clk) if (!s1.SRAM_WE_N && s1.sram_dq_oe) mem1[s1.SRAM_ADDR[3:0]] <= s1.sram_dq_out;
  always @(posedge clk) if (!s2.SRAM_WE_N && s2.sram_dq_oe) mem2[s2.SRAM_ADDR[3:0]] <= s2.sram_dq_out;
  mem_stage dut (
    .clk(clk), .rst(rst), .exe_wb_enable(wb1), .exe_mem_read(rd1), .exe_mem_write(wr1),
    .exe_reg_dest(dst1), .exe_alu_result(res1), .exe_val_rm(val1),
    .MEM_wb_enable(mwb1), .MEM_reg_dest(mdst1), .MEM_alu_result(malu1), .mem_read_out(mrd1),
    .mem_rdata(rdata1), .freeze(f1), .wb_valid(v1), .sram(s1)
  );
  mem_stage #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .exe_wb_enable(1'b0), .exe_mem_read(1'b0), .exe_mem_write(wr2),
    .exe_reg_dest('0), .exe_alu_result(res2), .exe_val_rm(val2),
    .MEM_wb_enable(mwb2), .MEM_reg_dest(mdst2), .MEM_alu_result(malu2), .mem_read_out(mrd2),
    .mem_rdata(rdata2), .freeze(f2), .wb_valid(v2), .sram(s2)
  );
  int errors = 0, checks = 0;
  int cyc, lo, hi, c1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_stall(input bit sel, output int n, output int nlo, output int nhi);
    n = 0;
    nlo = 0;
    nhi = 0;
    while ((sel ? f2 : f1) && n < 40) begin
      if (sel ? !s2.SRAM_WE_N : !s1.SRAM_WE_N) begin
        if (sel ? s2.SRAM_ADDR[0] : s1.SRAM_ADDR[0]) nhi++;
        else nlo++;
      end
      n++;
      step();
    end
  endtask
  task automatic exe(input logic wb, input logic rd, input logic wr, input int dst, input logic [31:0] res, input logic [31:0] val);
    wb1 = wb;
    rd1 = rd;
    wr1 = wr;
    dst1 = LEN_REG_ADDRESS'(dst);
    res1 = res;
    val1 = val;
  endtask
  initial begin
    step();
    step();
    check("rst_freeze", 32'(f1), 0);
    check("rst_wb_valid", 32'(v1), 1);
    check("rst_we_n", 32'(s1.SRAM_WE_N), 1);
    check("rst_oe", 32'(s1.sram_dq_oe), 0);
    check("rst_addr", 32'(s1.SRAM_ADDR), 0);
    check("rst_rdata", rdata1, 0);
    rst = 0;
    exe(1, 0, 0, 3, 32'h55, 0);
    step();
    check("add_wb", 32'(mwb1), 1);
    check("add_dst", 32'(mdst1), 3);
    check("add_alu", malu1, 32'h55);
    check("add_freeze", 32'(f1), 0);
    exe(0, 0, 1, 1, 1028, 32'hDEADBEEF);
    step();
    exe(0, 0, 0, 0, 0, 0);
    run_stall(0, cyc, lo, hi);
    check("st_freeze_cycles", cyc, 10);
    check("st_we_lo", lo, 4);
    check("st_we_hi", hi, 4);
    check("st_mem2", 32'(mem1[2]), 32'hBEEF);
    check("st_mem3", 32'(mem1[3]), 32'hDEAD);
    check("st_done_alu", malu1, 1028);
    exe(1, 1, 0, 5, 1028, 0);
    step();
    check("ld_b2b_freeze", 32'(f1), 1);
    check("ld_oe", 32'(s1.sram_dq_oe), 0);
    exe(1, 0, 0, 7, 32'h77, 0);
    run_stall(0, cyc, lo, hi);
    check("ld_freeze_cycles", cyc, 10);
    check("ld_we_lo", lo, 0);
    check("ld_we_hi", hi, 0);
    check("ld_rdata", rdata1, 32'hDEADBEEF);
    check("ld_wb_valid", 32'(v1), 1);
    check("ld_rd_out", 32'(mrd1), 1);
    check("ld_held_dst", 32'(mdst1), 5);
    check("ld_held_alu", malu1, 1028);
    step();
    check("next_dst", 32'(mdst1), 7);
    check("next_alu", malu1, 32'h77);
    check("next_freeze", 32'(f1), 0);
    exe(1, 1, 0, 6, 1032, 0);
    step();
    exe(0, 0, 1, 2, 1036, 32'hCAFEF00D);
    run_stall(0, c1, lo, hi);
    check("ls_ld_cycles", c1, 10);
    check("ls_ld_rdata", rdata1, 32'h56781234);
    check("ls_held_alu", malu1, 1032);
    check("ls_held_dst", 32'(mdst1), 6);
    step();
    check("ls_no_idle", 32'(f1), 1);
    exe(0, 0, 0, 0, 0, 0);
    run_stall(0, cyc, lo, hi);
    check("ls_total_stall", c1 + cyc, 20);
    check("ls_we_lo", lo, 4);
    check("ls_we_hi", hi, 4);
    check("ls_mem6", 32'(mem1[6]), 32'hF00D);
    check("ls_mem7", 32'(mem1[7]), 32'hCAFE);
    step();
    exe(1, 0, 1, 9, 1040, 32'h11112222);
    step();
    exe(0, 0, 0, 0, 0, 0);
    repeat (7) step();
    check("mid_freeze", 32'(f1), 1);
    check("mid_addr", 32'(s1.SRAM_ADDR), 9);
    check("mid_we_n", 32'(s1.SRAM_WE_N), 0);
    rst = 1;
    step();
    rst = 0;
    check("mr_freeze", 32'(f1), 0);
    check("mr_wb_valid", 32'(v1), 1);
    check("mr_we_n", 32'(s1.SRAM_WE_N), 1);
    check("mr_oe", 32'(s1.sram_dq_oe), 0);
    check("mr_addr", 32'(s1.SRAM_ADDR), 0);
    check("mr_wb", 32'(mwb1), 0);
    check("mr_dst", 32'(mdst1), 0);
    check("mr_alu", malu1, 0);
    check("mr_rd_out", 32'(mrd1), 0);
    check("mr_rdata", rdata1, 0);
    step();
    check("mr_stays_idle", 32'(f1), 0);
    wr2 = 1;
    res2 = 1024;
    val2 = 32'hA5A55A5A;
    step();
    wr2 = 0;
    res2 = 0;
    val2 = 0;
    run_stall(1, cyc, lo, hi);
    check("w2_freeze_cycles", cyc, 4);
    check("w2_we_lo", lo, 1);
    check("w2_we_hi", hi, 1);
    check("w2_mem0", 32'(mem2[0]), 32'h5A5A);
    check("w2_mem1", 32'(mem2[1]), 32'hA5A5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

EXE→MEM pipeline register plus a sequencer for the external 16-bit SRAM data memory. Captures the EXE stage result each cycle, stalls the whole pipeline (`freeze`) while a 32-bit load or store is split into two 16-bit SRAM accesses, and delivers the result to the MEM/WB register. Its registered `MEM_wb_enable`, `MEM_reg_dest` and `MEM_alu_result` are the MEM-side inputs of the forwarding unit and hazard unit.

## Interface
Parameters:
- `WAIT_CYCLES`, 5: cycles per 16-bit SRAM access; legal range ≥ 2.
- `DATA_MEM_BASE`, 1024: byte address of data memory; subtracted before SRAM addressing.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `exe_wb_enable`  in  1  EXE instruction writes the register file.
- `exe_mem_read`  in  1  EXE instruction is a load.
- `exe_mem_write`  in  1  EXE instruction is a store.
- `exe_reg_dest`  in  `LEN_REG_ADDRESS`  destination register.
- `exe_alu_result`  in  32  ALU result / byte address.
- `exe_val_rm`  in  32  store data.
- `MEM_wb_enable`  out  1  registered; to forwarding/hazard units.
- `MEM_reg_dest`  out  `LEN_REG_ADDRESS`  registered.
- `MEM_alu_result`  out  32  registered; forwarded value.
- `mem_read_out`  out  1  registered load flag for MEM/WB.
- `mem_rdata`  out  32  load data, valid in `DONE`.
- `freeze`  out  1  combinational; stalls PC, IF/ID, ID/EXE and this block.
- `wb_valid`  out  1  `~freeze`; MEM/WB captures only when high.
- `SRAM_ADDR`  out  18  half-word address.
- `SRAM_WE_N`  out  1  active-low write strobe.
- `sram_dq_out`  out  16  write data.
- `sram_dq_oe`  out  1  drive enable for the board-level tristate.
- `sram_dq_in`  in  16  read data.

## Operation
- Pipeline register loads all `exe_*` fields when `freeze`=0, holds otherwise.
- Word index `w = (MEM_alu_result - DATA_MEM_BASE) >> 2`, 16 bits. Low half at `{w,1'b0}`, high half at `{w,1'b1}`. Address bits [1:0] are ignored.
- FSM states: `IDLE`, `LO`, `HI`, `DONE`. Counter `cnt` ranges 0..`WAIT_CYCLES`-1.
  - `IDLE`/`DONE`: a capture of a load or store goes to `LO` with `cnt`=0. Any other capture goes to `IDLE`.
  - `LO`: `cnt` increments each cycle. At `cnt`=`WAIT_CYCLES`-1, go to `HI` with `cnt`=0. On a load, latch `sram_dq_in` into the low half.
  - `HI`: same as `LO`. At the last cycle, latch the high half and go to `DONE`.
- `freeze` = state ∈ {`LO`,`HI`}.
- Writes: `SRAM_WE_N`=0 for `cnt` 0..`WAIT_CYCLES`-2 of each half, and 1 on the last cycle for hold. `sram_dq_oe`=1 throughout `LO`/`HI`. `sram_dq_out` = `val_rm[15:0]` in `LO`, `val_rm[31:16]` in `HI`.
- Reads: `SRAM_WE_N`=1, `sram_dq_oe`=0.
- `SRAM_ADDR` is held stable for the whole half.
- Simultaneous read and write flags: treated as a write.

## Timing
- Non-memory instruction: 1 cycle in this stage; `freeze` stays 0.
- Memory instruction: resident 2·`WAIT_CYCLES`+1 cycles. `freeze` is high for 2·`WAIT_CYCLES` cycles, starting the cycle after capture. `mem_rdata` is valid during `DONE`.
- Back-to-back memory ops: `DONE` → `LO` directly. No idle gap.
- Reset (any state, including mid-access): at that edge, state=`IDLE`, `cnt`=0, and all registered outputs become 0. Resulting values: `SRAM_WE_N`=1, `sram_dq_oe`=0, `freeze`=0, `wb_valid`=1, `mem_rdata`=0, `SRAM_ADDR`=0. A partial store may remain in SRAM; this is acceptable.
- `MEM_*` outputs are held constant during `freeze`, so forwarding stays consistent.

## Structure
- Add to `ISA.v`:
  - `` `MEM_ST_IDLE/LO/HI/DONE `` (2-bit encodings)
  - `` `LEN_SRAM_ADDR `` (18) and `` `LEN_SRAM_DATA `` (16)
  - `` `DATA_MEM_BASE `` default
- One sub-module, `sram_controller`: FSM, counter, SRAM pins, read-data assembly, `freeze`. `mem_stage` holds the pipeline register and instantiates it.

## Test plan
- Reset, then ADD-like instruction: `exe_wb_enable`=1, dest=3, result=0x55. Next cycle `MEM_wb_enable`=1, `MEM_reg_dest`=3, `MEM_alu_result`=0x55, `freeze`=0.
- Store 0xDEADBEEF to address 1028: `freeze` high for 10 cycles. `SRAM_ADDR`=2 carries 0xBEEF and `SRAM_ADDR`=3 carries 0xDEAD. `SRAM_WE_N` is low for 4 cycles per half.
- Load from 1028 with SRAM model holding 0xBEEF/0xDEAD: in `DONE`, `mem_rdata`=0xDEADBEEF and `wb_valid`=1. The following instruction is captured at the end of `DONE`.
- Load followed immediately by store: no `IDLE` cycle between them. Total stall is 20 cycles. The `exe_*` fields changing during `freeze` do not alter the `MEM_*` outputs.
- `rst` pulsed at `cnt`=2 of `HI` during a store: next cycle state=`IDLE`, `SRAM_WE_N`=1, `sram_dq_oe`=0, `freeze`=0, and all `MEM_*` outputs are 0.
- `WAIT_CYCLES`=2: store to 1024 gives a 4-cycle freeze, with `SRAM_WE_N` low exactly 1 cycle per half.
